// File: rtl/periferico_rx_pkg.sv
// Shared types and defaults for the peripheral-side receive buffer.
// State encoding is visible on the estado debug port.
package periferico_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACK  = 2'b01,
    BLOQ = 2'b10
  } estado_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals crossing into the local clock domain.
// Async active-high reset clears both stages.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/periferico_rx_buffer.sv
// 4-phase send/ack responder feeding a small FIFO with a valid/ready drain.
// Ack is withheld while the FIFO is full, stalling the sender.
module periferico_rx_buffer
  import periferico_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send,
  input  logic [WIDTH-1:0]       dados,
  output logic                   ack,
  output logic [1:0]             estado,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic [CNT_W-1:0]       rx_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             s2;
  estado_t          state, state_n;
  logic             ack_n;
  logic             push;
  logic             wr_q;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (send),
    .q   (s2)
  );

  always_comb begin
    state_n = state;
    ack_n   = ack;
    push    = 1'b0;
    case (state)
      IDLE: begin
        ack_n = 1'b0;
        if (s2 && !full) begin
          push    = 1'b1;
          ack_n   = 1'b1;
          state_n = ACK;
        end else if (s2) begin
          state_n = BLOQ;
        end
      end
      ACK: begin
        ack_n = 1'b1;
        if (!s2) begin
          ack_n   = 1'b0;
          state_n = IDLE;
        end
      end
      BLOQ: begin
        ack_n = 1'b0;
        if (s2 && !full) begin
          push    = 1'b1;
          ack_n   = 1'b1;
          state_n = ACK;
        end else if (!s2) begin
          state_n = IDLE;
        end
      end
      default: begin
        ack_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // The captured word lands in the FIFO one edge after the FSM accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ack      <= 1'b0;
      wr_q     <= 1'b0;
      wr_data  <= '0;
      rx_total <= '0;
    end else begin
      state <= state_n;
      ack   <= ack_n;
      wr_q  <= push;
      if (push) begin
        wr_data  <= dados;
        rx_total <= rx_total + 1'b1;
      end
    end
  end

  assign estado     = state;
  assign full       = (count == CW'(DEPTH));
  assign dout_valid = (count != '0);
  assign dout       = mem[rd_ptr];
  assign do_push    = wr_q && !full;
  assign do_pop     = dout_valid && dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_periferico_rx_buffer.sv
// Scoreboard bench for the receive buffer: sender model drives the
// handshake, consumer pops are checked against the expected word queue.
module tb_periferico_rx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [3:0] dados = '0;
  logic       ack;
  logic [1:0] estado;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [2:0] count;
  logic       full;
  logic [7:0] rx_total;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] sb [$];
  logic [7:0] exp_total = '0;

  always #5 clk = ~clk;

  periferico_rx_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .send       (send),
    .dados      (dados),
    .ack        (ack),
    .estado     (estado),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .full       (full),
    .rx_total   (rx_total)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input logic lv, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ack == lv) break;
    end
    chk("ack_wait", ack, lv);
  endtask

  task automatic hs(input logic [3:0] v);
    @(negedge clk);
    dados = v;
    send  = 1'b1;
    sb.push_back(v);
    exp_total++;
    wait_ack(1'b1, 10);
    send = 1'b0;
    wait_ack(1'b0, 10);
  endtask

  task automatic pop_one();
    logic [3:0] e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("pop_unexpected", dout_valid, 0);
    end else begin
      e = sb.pop_front();
      chk("pop_valid", dout_valid, 1);
      chk("pop_data", dout, e);
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
    end
  endtask

  initial begin
    logic seen;
    logic [7:0] t0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_estado", estado, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_total", rx_total, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;

    // single word with exact latency
    @(negedge clk);
    dados = 4'hA;
    send  = 1'b1;
    sb.push_back(4'hA);
    exp_total++;
    repeat (2) @(negedge clk);
    chk("rise_early", ack, 0);
    @(negedge clk);
    chk("rise_3rd", ack, 1);
    @(negedge clk);
    chk("single_valid", dout_valid, 1);
    chk("single_dout", dout, 4'hA);
    chk("single_count", count, 1);
    chk("single_total", rx_total, 1);
    send = 1'b0;
    repeat (2) @(negedge clk);
    chk("fall_early", ack, 1);
    @(negedge clk);
    chk("fall_3rd", ack, 0);
    pop_one();

    // fill and stall
    for (int i = 1; i <= 4; i++) hs(4'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    @(negedge clk);
    dados = 4'h5;
    send  = 1'b1;
    sb.push_back(4'h5);
    exp_total++;
    repeat (6) @(negedge clk);
    chk("stall_estado", estado, 2);
    chk("stall_ack", ack, 0);
    chk("stall_full", full, 1);
    pop_one();
    chk("stall_count", count, 3);
    wait_ack(1'b1, 3);
    send = 1'b0;
    wait_ack(1'b0, 10);
    chk("stall_refill", count, 4);
    repeat (4) pop_one();
    chk("drained", dout_valid, 0);

    // push and pop on the same edge
    hs(4'h6);
    hs(4'h7);
    @(negedge clk);
    dados = 4'h8;
    send  = 1'b1;
    sb.push_back(4'h8);
    exp_total++;
    wait_ack(1'b1, 10);
    chk("pp_head", dout, sb.pop_front());
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk("pp_count", count, 2);
    chk("pp_next", dout, 4'h7);
    send = 1'b0;
    wait_ack(1'b0, 10);
    repeat (2) pop_one();

    // held send with changing dados
    t0 = rx_total;
    @(negedge clk);
    dados = 4'h9;
    send  = 1'b1;
    sb.push_back(4'h9);
    exp_total++;
    wait_ack(1'b1, 10);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      dados = 4'($urandom);
    end
    chk("held_total", rx_total, t0 + 8'd1);
    chk("held_count", count, 1);
    send = 1'b0;
    wait_ack(1'b0, 10);
    pop_one();
    chk("held_empty", dout_valid, 0);

    // reset in the middle of a handshake
    hs(4'h1);
    hs(4'h2);
    @(negedge clk);
    dados = 4'h3;
    send  = 1'b1;
    wait_ack(1'b1, 10);
    @(negedge clk);
    chk("pre_rst_count", count, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_estado", estado, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(4'h3);
    exp_total = 8'd1;
    wait_ack(1'b1, 10);
    chk("rst_recap_total", rx_total, 1);
    send = 1'b0;
    wait_ack(1'b0, 10);
    pop_one();

    // withdrawn request while blocked
    for (int i = 0; i < 4; i++) hs(4'(i + 4'hB));
    @(negedge clk);
    dados = 4'hC;
    send  = 1'b1;
    seen  = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= ack;
    end
    chk("wd_bloq", estado, 2);
    send = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= ack;
    end
    chk("wd_idle", estado, 0);
    chk("wd_no_ack", seen, 0);
    chk("wd_count", count, 4);
    chk("wd_total", rx_total, exp_total);
    repeat (4) pop_one();

    // counter wrap
    while (exp_total != 8'hFF) begin
      hs(4'(exp_total));
      pop_one();
    end
    chk("wrap_ff", rx_total, 8'hFF);
    hs(4'hE);
    chk("wrap_zero", rx_total, 0);
    pop_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
